// File: rtl/keccak_msg_feeder_pkg.sv
// Shared types and constants for the Keccak-512 byte-stream feeder.
// FSM state encoding plus word/digest geometry.
package keccak_msg_feeder_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT  = 3'd0,
    ST_SEND     = 3'd1,
    ST_SEND_PAD = 3'd2,
    ST_WAIT     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int DIGEST_W       = 512;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/keccak_msg_feeder_if.sv
// Byte-stream, core-word and digest signals of the feeder.
// master = environment (byte source + core), slave = feeder.
interface keccak_msg_feeder_if;
  import keccak_msg_feeder_pkg::*;

  logic [7:0]          s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic                msg_empty;
  logic [WORD_W-1:0]   in;
  logic                in_ready;
  logic                is_last;
  logic [1:0]          byte_num;
  logic                buffer_full;
  logic [DIGEST_W-1:0] out;
  logic                out_ready;
  logic [DIGEST_W-1:0] digest;
  logic                done;
  logic                timeout;

  modport master (
    output s_data, s_valid, s_last, msg_empty, buffer_full, out, out_ready,
    input  s_ready, in, in_ready, is_last, byte_num, digest, done, timeout
  );

  modport slave (
    input  s_data, s_valid, s_last, msg_empty, buffer_full, out, out_ready,
    output s_ready, in, in_ready, is_last, byte_num, digest, done, timeout
  );

endinterface

// File: rtl/keccak_byte_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word; flags word completion.
// The completed word is combinational with the accepting byte so the FSM can register it that edge.
module keccak_byte_packer
  import keccak_msg_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              last,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic [2:0]        nbytes,
  output logic              word_done,
  output logic              word_last
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        shamt;

  always_comb begin
    // byte at position cnt lands in bits [31-8*cnt -: 8]; unused low bytes stay zero
    shamt     = {~cnt_q, 3'b000};
    word      = sr_q | (WORD_W'(data) << shamt);
    nbytes    = {1'b0, cnt_q} + {2'b00, accept};
    word_last = accept & last;
    word_done = accept & (last | (cnt_q == CNT_W'(BYTES_PER_WORD - 1)));
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    if (word_done) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      sr_d  = word;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keccak_msg_feeder.sv
// Byte-stream front end for the 32-bit Keccak-512 core: packs, sends words, captures digest.
// One message per reset; words are held stable while the core raises buffer_full.
module keccak_msg_feeder
  import keccak_msg_feeder_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4095
) (
  input  logic                clk,
  input  logic                reset,
  keccak_msg_feeder_if.slave  bus
);

  localparam int WD_W = $clog2(MAX_WAIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_WAIT - 1);

  state_e              state_q, state_d;
  logic                pad_q, pad_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [WORD_W-1:0]   in_q, in_d;
  logic                in_ready_q, in_ready_d;
  logic                is_last_q, is_last_d;
  logic [1:0]          byte_num_q, byte_num_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                s_ready_q, s_ready_d;

  logic [WORD_W-1:0] pk_word;
  logic [2:0]        pk_nbytes;
  logic              pk_word_done, pk_word_last;
  logic              accept, empty_req, word_acc, full_word;

  assign accept    = bus.s_valid & s_ready_q;
  assign empty_req = bus.msg_empty & s_ready_q & ~bus.s_valid & (pk_nbytes == 3'd0);
  assign word_acc  = in_ready_q & ~bus.buffer_full;
  assign full_word = (pk_nbytes == 3'(BYTES_PER_WORD));

  keccak_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .last      (bus.s_last),
    .data      (bus.s_data),
    .word      (pk_word),
    .nbytes    (pk_nbytes),
    .word_done (pk_word_done),
    .word_last (pk_word_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_COLLECT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_COLLECT: begin
        if (pk_word_done)   state_d = ST_SEND;
        else if (empty_req) state_d = ST_SEND_PAD;
      end
      ST_SEND: begin
        if (word_acc) begin
          if (pad_q)          state_d = ST_SEND_PAD;
          else if (is_last_q) state_d = ST_WAIT;
          else                state_d = ST_COLLECT;
        end
      end
      ST_SEND_PAD: if (word_acc) state_d = ST_WAIT;
      ST_WAIT:     if (bus.out_ready || wd_q == WD_LAST) state_d = ST_DONE;
      ST_DONE:     state_d = ST_DONE;
      default:     state_d = ST_DONE;
    endcase
  end

  always_comb begin
    pad_d      = pad_q;
    wd_d       = wd_q;
    in_d       = in_q;
    in_ready_d = in_ready_q;
    is_last_d  = is_last_q;
    byte_num_d = byte_num_q;
    digest_d   = digest_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    s_ready_d  = (state_d == ST_COLLECT);
    unique case (state_q)
      ST_COLLECT: begin
        if (pk_word_done) begin
          // a 4-byte last word cannot carry is_last; it is followed by an empty pad word
          in_d       = pk_word;
          in_ready_d = 1'b1;
          is_last_d  = pk_word_last & ~full_word;
          byte_num_d = (pk_word_last & ~full_word) ? pk_nbytes[1:0] : 2'd0;
          pad_d      = pk_word_last & full_word;
        end else if (empty_req) begin
          in_d       = '0;
          in_ready_d = 1'b1;
          is_last_d  = 1'b1;
          byte_num_d = 2'd0;
        end
      end
      ST_SEND: begin
        if (word_acc) begin
          in_d       = '0;
          in_ready_d = pad_q;
          is_last_d  = pad_q;
          byte_num_d = 2'd0;
          pad_d      = 1'b0;
        end
      end
      ST_SEND_PAD: begin
        if (word_acc) begin
          in_d       = '0;
          in_ready_d = 1'b0;
          is_last_d  = 1'b0;
          byte_num_d = 2'd0;
        end
      end
      ST_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.out_ready) begin
          digest_d = bus.out;
          done_d   = 1'b1;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pad_q      <= 1'b0;
      wd_q       <= '0;
      in_q       <= '0;
      in_ready_q <= 1'b0;
      is_last_q  <= 1'b0;
      byte_num_q <= 2'd0;
      digest_q   <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      pad_q      <= pad_d;
      wd_q       <= wd_d;
      in_q       <= in_d;
      in_ready_q <= in_ready_d;
      is_last_q  <= is_last_d;
      byte_num_q <= byte_num_d;
      digest_q   <= digest_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.in       = in_q;
  assign bus.in_ready = in_ready_q;
  assign bus.is_last  = is_last_q;
  assign bus.byte_num = byte_num_q;
  assign bus.digest   = digest_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed bench for keccak_msg_feeder; the bench plays both byte source and Keccak core.
module tb_keccak_msg_feeder;
  import keccak_msg_feeder_pkg::*;

  localparam logic [511:0] KECCAK_ABC =
    512'h18587dc2ea106b9a1563e32b3312421ca164c7f1f07bc922a9c83d77cea3a1e5d0c69910739025372dc14ac9642629379540c17e2a65b19d77aa511a9d00bb96;
  localparam logic [511:0] KECCAK_EMPTY =
    512'h0eab42de4c3ceb9235fc91acffe746b29c29a8c366b7c60e4e67c466f36a4304c00fa9caf9d87976ba469bcbe06713b435f091ef2769fb160cdab33d3670680e;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  keccak_msg_feeder_if bus ();

  keccak_msg_feeder #(.MAX_WAIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last, input logic me);
    int n = 0;
    while (!bus.s_ready && n < 20) begin
      tick();
      n++;
    end
    chk("s_ready_before_byte", bus.s_ready, 1'b1);
    bus.s_data    = b;
    bus.s_valid   = 1'b1;
    bus.s_last    = last;
    bus.msg_empty = me;
    tick();
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.msg_empty = 1'b0;
  endtask

  // Waits for the expected word, checks it every presented cycle (stability), accepts it once.
  task automatic consume_word(input logic [31:0] ew, input logic el, input logic [1:0] eb,
                              input logic rnd, input logic next_rdy);
    int   n   = 0;
    logic acc = 1'b0;
    logic bf;
    while (!acc && n < 100) begin
      bf = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.buffer_full = bf;
      if (bus.in_ready) begin
        chk("word_in", bus.in, ew);
        chk("word_is_last", bus.is_last, el);
        chk("word_byte_num", bus.byte_num, eb);
        if (!bf) acc = 1'b1;
      end
      tick();
      n++;
    end
    bus.buffer_full = 1'b0;
    chk("word_accepted", acc, 1'b1);
    chk("in_ready_after_accept", bus.in_ready, next_rdy);
  endtask

  task automatic finish_digest(input logic [511:0] vec);
    bus.out       = vec;
    bus.out_ready = 1'b1;
    chk("done_before_out_ready", bus.done, 1'b0);
    tick();
    chk("done_rise", bus.done, 1'b1);
    chk("digest", bus.digest, vec);
    chk("no_timeout", bus.timeout, 1'b0);
    bus.out       = ~vec;
    bus.s_valid   = 1'b1;
    bus.msg_empty = 1'b1;
    tick();
    chk("digest_hold", bus.digest, vec);
    chk("done_s_ready", bus.s_ready, 1'b0);
    chk("done_in_ready", bus.in_ready, 1'b0);
    bus.s_valid   = 1'b0;
    bus.msg_empty = 1'b0;
    bus.out_ready = 1'b0;
    bus.out       = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    chk("rst_done", bus.done, 1'b0);
    chk("rst_digest", bus.digest, 512'd0);
    chk("rst_timeout", bus.timeout, 1'b0);
    chk("rst_s_ready", bus.s_ready, 1'b0);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] w;
    bus.s_data = 8'd0;  bus.s_valid = 1'b0;  bus.s_last = 1'b0;  bus.msg_empty = 1'b0;
    bus.buffer_full = 1'b0;  bus.out = '0;  bus.out_ready = 1'b0;

    // reset state
    tick();
    tick();
    chk("reset_s_ready", bus.s_ready, 1'b0);
    chk("reset_in", bus.in, 32'd0);
    chk("reset_in_ready", bus.in_ready, 1'b0);
    chk("reset_is_last", bus.is_last, 1'b0);
    chk("reset_byte_num", bus.byte_num, 2'd0);
    chk("reset_digest", bus.digest, 512'd0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_timeout", bus.timeout, 1'b0);
    reset = 1'b1;
    tick();
    chk("release_s_ready", bus.s_ready, 1'b1);

    // "abc": one partial last word
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0);
    chk("abc_no_early_word", bus.in_ready, 1'b0);
    send_byte(8'h63, 1'b1, 1'b0);
    chk("abc_word_latency", bus.in_ready, 1'b1);
    chk("abc_s_ready_low", bus.s_ready, 1'b0);
    consume_word(32'h61626300, 1'b1, 2'd3, 1'b0, 1'b0);
    finish_digest(KECCAK_ABC);
    do_reset();

    // 8 bytes: two full words then an empty pad word; msg_empty with cnt!=0 is ignored
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b1);
    bus.msg_empty = 1'b1;
    tick();
    bus.msg_empty = 1'b0;
    chk("empty_ignored_s_ready", bus.s_ready, 1'b1);
    chk("empty_ignored_in_ready", bus.in_ready, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    consume_word(32'h00010203, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 4; i < 8; i++) send_byte(8'(i), (i == 7), 1'b0);
    consume_word(32'h04050607, 1'b0, 2'd0, 1'b0, 1'b1);
    consume_word(32'h00000000, 1'b1, 2'd0, 1'b0, 1'b0);
    finish_digest({16{32'h0badcafe}});
    do_reset();

    // empty message
    bus.msg_empty = 1'b1;
    tick();
    bus.msg_empty = 1'b0;
    chk("empty_in_ready", bus.in_ready, 1'b1);
    consume_word(32'h00000000, 1'b1, 2'd0, 1'b0, 1'b0);
    finish_digest(KECCAK_EMPTY);
    do_reset();

    // 200 bytes under random back-pressure
    for (int wi = 0; wi < 50; wi++) begin
      for (int k = 0; k < 4; k++) send_byte(pat(wi * 4 + k), (wi * 4 + k == 199), 1'b0);
      w = {pat(wi * 4), pat(wi * 4 + 1), pat(wi * 4 + 2), pat(wi * 4 + 3)};
      consume_word(w, 1'b0, 2'd0, 1'b1, (wi == 49));
    end
    consume_word(32'h00000000, 1'b1, 2'd0, 1'b1, 1'b0);
    finish_digest({8{64'h0123456789abcdef}});
    do_reset();

    // watchdog: out_ready never comes
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b1, 1'b0);
    consume_word(32'h61620000, 1'b1, 2'd2, 1'b0, 1'b0);
    repeat (15) tick();
    chk("timeout_not_yet", bus.timeout, 1'b0);
    tick();
    chk("timeout_at_16", bus.timeout, 1'b1);
    chk("timeout_done_low", bus.done, 1'b0);
    chk("timeout_s_ready", bus.s_ready, 1'b0);
    do_reset();

    // asynchronous reset mid-word, then a fresh "abc"
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    chk("midword_s_ready", bus.s_ready, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk("async_s_ready", bus.s_ready, 1'b0);
    chk("async_in_ready", bus.in_ready, 1'b0);
    chk("async_in", bus.in, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    send_byte(8'h61, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0);
    send_byte(8'h63, 1'b1, 1'b0);
    consume_word(32'h61626300, 1'b1, 2'd3, 1'b0, 1'b0);
    finish_digest(KECCAK_ABC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
